// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_ctrl
// Description : Command/response front end for a 1W/2R register file.
//               Absorbs the 1-cycle read latency and uses a credit-limited
//               response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 32,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int CMD_ADDR_WIDTH = ADDR_WIDTH + 1,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [CMD_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]          cmd_wdata,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      rsp_err,

    output logic                      rf_write_en,
    output logic [ADDR_WIDTH-1:0]     rf_write_addr,
    output logic [WIDTH-1:0]          rf_write_data,
    output logic                      rf_read_en1,
    output logic [ADDR_WIDTH-1:0]     rf_read_addr1,
    input  logic [WIDTH-1:0]          rf_read_data1,

    output logic                      busy
);

    localparam int c_ptr_w = $clog2(RSP_DEPTH);
    localparam int c_cnt_w = $clog2(RSP_DEPTH + 1);

    localparam logic [CMD_ADDR_WIDTH-1:0] c_depth   = CMD_ADDR_WIDTH'(DEPTH);
    localparam logic [c_cnt_w:0]          c_credit  = (c_cnt_w + 1)'(RSP_DEPTH);
    localparam logic [c_ptr_w-1:0]        c_ptr_max = c_ptr_w'(RSP_DEPTH - 1);

    logic                 r_inflight;
    logic                 r_err;
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_data_mem [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] r_err_mem;

    logic                 w_in_range;
    logic                 w_accept;
    logic                 w_rd_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_cmd_ready;
    logic [c_cnt_w:0]     w_used;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_max) ? '0 : ptr + c_ptr_w'(1);
    endfunction

    // Credit counts the read in the capture stage so a push can never overflow.
    assign w_used      = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_cmd_ready = rst_n && (w_used < c_credit);
    assign cmd_ready   = w_cmd_ready;

    assign w_in_range  = (cmd_addr < c_depth);
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_rd_accept = w_accept && !cmd_write;

    assign rf_write_en   = w_accept && cmd_write && w_in_range;
    assign rf_write_addr = cmd_addr[ADDR_WIDTH-1:0];
    assign rf_write_data = cmd_wdata;
    assign rf_read_en1   = w_rd_accept && w_in_range;
    assign rf_read_addr1 = cmd_addr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_accept;
            if (w_rd_accept) begin
                r_err <= !w_in_range;
            end
        end
    end

    assign w_push = r_inflight;
    assign w_pop  = rsp_valid && rsp_ready;

    // Storage needs no reset: entries are only visible through a valid count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wptr] <= r_err ? '0 : rf_read_data1;
            r_err_mem[r_wptr]  <= r_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rsp_valid = (r_count != '0);
    assign rsp_rdata = rsp_valid ? r_data_mem[r_rptr] : '0;
    assign rsp_err   = rsp_valid ? r_err_mem[r_rptr]  : 1'b0;
    assign busy      = r_inflight || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_access_ctrl
// Description : Directed bench for regfile_access_ctrl with a behavioural
//               register file model (registered 1-cycle read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_access_ctrl;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int CAW   = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [CAW-1:0]   cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rf_write_en, rf_read_en1, busy;
    logic [AW-1:0]    rf_write_addr, rf_read_addr1;
    logic [WIDTH-1:0] rf_write_data, rf_read_data1;

    logic             tb_init;
    logic [WIDTH-1:0] rf_mem [32];
    logic [WIDTH-1:0] rf_rd;
    int               cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] q_data [$];
    logic             q_err  [$];
    int               q_cyc  [$];

    regfile_access_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_read_en1   (rf_read_en1),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_data1 (rf_read_data1),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            rf_rd <= '0;
        end else begin
            if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;
            if (rf_read_en1) rf_rd <= rf_mem[rf_read_addr1];
        end
    end
    assign rf_read_data1 = rf_rd;

    // Inputs change on negedge; a handshake seen here completes at the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && rsp_ready) begin
                q_data.push_back(rsp_rdata);
                q_err.push_back(rsp_err);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [CAW-1:0] a, input logic [WIDTH-1:0] d,
                         output int acc);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        #1;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("cmd_accept", guard < 50, 1);
        acc = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n);
        int guard = 0;
        while (q_data.size() < n && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check(tag, q_data.size(), n);
    endtask

    task automatic expect_rsp(input string tag, input logic [WIDTH-1:0] d, input logic e,
                              output int rcyc);
        rcyc = -1;
        if (q_data.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            rcyc = q_cyc.pop_front();
            check({tag, "_data"}, q_data.pop_front(), d);
            check({tag, "_err"}, q_err.pop_front(), e);
        end
    endtask

    initial begin
        int acc, acc_r, rc, prev;
        int acc_a [8];

        rst_n     = 1'b0;
        tb_init   = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 6'd5;
        cmd_wdata = 32'h1234_5678;
        rsp_ready = 1'b0;

        // Reset state, with a write presented to prove the gating
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", rf_write_en, 0);
        check("rst_rd_en", rf_read_en1, 0);
        tb_init = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;

        // Write then read back with minimum latency
        issue(1'b1, 6'd5, 32'hDEAD_BEEF, acc);
        check("t1_wr_en", rf_write_en, 1);
        check("t1_wr_addr", rf_write_addr, 5);
        check("t1_wr_data", rf_write_data, 32'hDEAD_BEEF);
        issue(1'b0, 6'd5, 32'h0, acc_r);
        check("t1_wr_pulse", rf_write_en, 0);
        check("t1_rd_en", rf_read_en1, 1);
        check("t1_rd_addr", rf_read_addr1, 5);
        idle();
        wait_rsp("t1_rsp_count", 1);
        expect_rsp("t1_rsp", 32'hDEAD_BEEF, 1'b0, rc);
        check("t1_latency", rc - acc_r, 2);

        // Preload and back-to-back reads
        for (int i = 0; i < 9; i++) issue(1'b1, 6'(i), 32'(i * 3), acc);
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 6'(i), 32'h0, acc_a[i]);
            if (i > 0) check("t2_accept_gap", acc_a[i] - acc_a[i-1], 1);
        end
        idle();
        wait_rsp("t2_rsp_count", 8);
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            expect_rsp("t2_rsp", 32'(i * 3), 1'b0, rc);
            if (i > 0) check("t2_rsp_gap", rc - prev, 1);
            prev = rc;
        end

        // Back-pressure: exactly RSP_DEPTH reads accepted while stalled
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 6'(i), 32'h0, acc_a[i]);
            if (i > 0) check("t3_accept_gap", acc_a[i] - acc_a[i-1], 1);
        end
        @(negedge clk);
        cmd_addr = 6'd4;
        #1;
        check("t3_stall_ready", cmd_ready, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("t3_stall_ready", cmd_ready, 0);
            check("t3_stall_valid", rsp_valid, 1);
            check("t3_stall_busy", busy, 1);
        end
        check("t3_no_early_rsp", q_data.size(), 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        issue(1'b0, 6'd4, 32'h0, acc);
        issue(1'b0, 6'd5, 32'h0, acc);
        idle();
        wait_rsp("t3_rsp_count", 6);
        for (int i = 0; i < 6; i++) expect_rsp("t3_rsp", 32'(i * 3), 1'b0, rc);

        // Out-of-range read and write
        issue(1'b0, 6'd32, 32'h0, acc);
        check("t4_rd_en", rf_read_en1, 0);
        issue(1'b1, 6'd40, 32'h0000_0BAD, acc);
        check("t4_wr_en", rf_write_en, 0);
        idle();
        wait_rsp("t4_rsp_count", 1);
        expect_rsp("t4_rsp", 32'h0, 1'b1, rc);
        check("t4_reg8_model", rf_mem[8], 24);
        issue(1'b0, 6'd8, 32'h0, acc);
        idle();
        wait_rsp("t4_rb_count", 1);
        expect_rsp("t4_rb", 32'd24, 1'b0, rc);

        // Read-after-write and write-after-read ordering
        issue(1'b1, 6'd10, 32'h55, acc);
        issue(1'b1, 6'd9, 32'h11, acc);
        issue(1'b0, 6'd9, 32'h0, acc);
        issue(1'b0, 6'd10, 32'h0, acc);
        issue(1'b1, 6'd10, 32'h22, acc);
        issue(1'b0, 6'd10, 32'h0, acc);
        idle();
        wait_rsp("t5_rsp_count", 3);
        expect_rsp("t5_raw", 32'h11, 1'b0, rc);
        expect_rsp("t5_war", 32'h55, 1'b0, rc);
        expect_rsp("t5_new", 32'h22, 1'b0, rc);

        // Asynchronous reset with one read in flight and two buffered
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 6'd0, 32'h0, acc);
        issue(1'b0, 6'd1, 32'h0, acc);
        issue(1'b0, 6'd2, 32'h0, acc);
        idle();
        #1;
        check("t6_pre_busy", busy, 1);
        check("t6_pre_valid", rsp_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", cmd_ready, 0);
        check("t6_rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("t6_no_rsp", q_data.size(), 0);
        check("t6_post_busy", busy, 0);
        check("t6_post_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
